// File: rtl/kbd_joypad.sv
// PS/2 set-2 scan bytes -> up to two NES pads with $4016/$4017 strobe/serial read; optional turbo under KBD_JOYPAD_TURBO_EN.
// Latency: joy_state updates 1 clock after the completing ps2_data_clk; joy_bit shifts 1 clock after rd.
// Backpressure: none; every ps2_data_clk byte is consumed, and rd/strobe act every cycle.
module kbd_joypad #(
    parameter int PLAYERS      = 2,
    parameter bit SOCD_NEUTRAL = 1'b1,
    parameter int TURBO_DIV    = 833333
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [7:0]             ps2_data,
    input  logic                   ps2_data_clk,
    input  logic                   strobe,
    input  logic [PLAYERS-1:0]     rd,
    output logic [PLAYERS-1:0]     joy_bit,
    output logic [8*PLAYERS-1:0]   joy_state
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_SKIP
    } dec_state_t;

    dec_state_t  state, state_nxt;
    logic [2:0]  skip_cnt, skip_cnt_nxt;
    logic        do_make, do_brk;
    logic        fake_shift;
    logic [4:0]  key;
    logic [15:0] btn, btn_nxt;
    logic [15:0] clean_nxt;
    logic [1:0]  turbo_nxt;
    logic        phase_nxt;

    // {hit, pad, button index}; E0-prefixed codes share the plain map
    function automatic logic [4:0] key_map(input logic [7:0] code);
        case (code)
            8'h1A:   key_map = 5'b1_0_000;
            8'h22:   key_map = 5'b1_0_001;
            8'h21:   key_map = 5'b1_0_010;
            8'h2A:   key_map = 5'b1_0_011;
            8'h75:   key_map = 5'b1_0_100;
            8'h72:   key_map = 5'b1_0_101;
            8'h6B:   key_map = 5'b1_0_110;
            8'h74:   key_map = 5'b1_0_111;
            8'h42:   key_map = 5'b1_1_000;
            8'h4B:   key_map = 5'b1_1_001;
            8'h31:   key_map = 5'b1_1_010;
            8'h3A:   key_map = 5'b1_1_011;
            8'h1D:   key_map = 5'b1_1_100;
            8'h1B:   key_map = 5'b1_1_101;
            8'h1C:   key_map = 5'b1_1_110;
            8'h23:   key_map = 5'b1_1_111;
            default: key_map = 5'b0_0_000;
        endcase
    endfunction

    assign key        = key_map(ps2_data);
    assign fake_shift = (ps2_data == 8'h12) || (ps2_data == 8'h59);

    always_comb begin
        state_nxt    = state;
        skip_cnt_nxt = skip_cnt;
        do_make      = 1'b0;
        do_brk       = 1'b0;
        if (ps2_data_clk) begin
            case (state)
                S_IDLE: begin
                    if (ps2_data == 8'hE0) begin
                        state_nxt = S_EXT;
                    end else if (ps2_data == 8'hF0) begin
                        state_nxt = S_BRK;
                    end else if (ps2_data == 8'hE1) begin
                        state_nxt    = S_SKIP;
                        skip_cnt_nxt = 3'd7;
                    end else begin
                        do_make = 1'b1;
                    end
                end
                S_EXT: begin
                    state_nxt = S_IDLE;
                    if (ps2_data == 8'hF0) begin
                        state_nxt = S_EXT_BRK;
                    end else if (!fake_shift) begin
                        do_make = 1'b1;
                    end
                end
                S_BRK: begin
                    state_nxt = S_IDLE;
                    do_brk    = 1'b1;
                end
                S_EXT_BRK: begin
                    state_nxt = S_IDLE;
                    do_brk    = !fake_shift;
                end
                S_SKIP: begin
                    // Pause: E1 plus seven trailing bytes, none of which reach the keymap
                    if (skip_cnt == 3'd1) begin
                        state_nxt = S_IDLE;
                    end else begin
                        skip_cnt_nxt = skip_cnt - 3'd1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        btn_nxt = btn;
        if ((do_make || do_brk) && key[4] && (int'(key[3]) < PLAYERS)) begin
            btn_nxt[key[3:0]] = do_make;
        end
    end

`ifdef KBD_JOYPAD_TURBO_EN
    localparam int TCW = $clog2(TURBO_DIV + 1);

    logic [TCW-1:0] tcnt;
    logic           phase;
    logic [1:0]     turbo;
    logic           tc_wrap;

    assign tc_wrap = (tcnt == TCW'(TURBO_DIV - 1));

    always_comb begin
        turbo_nxt = turbo;
        if (do_make && ps2_data == 8'h05) begin
            turbo_nxt[0] = ~turbo[0];
        end
        if (do_make && ps2_data == 8'h06 && PLAYERS > 1) begin
            turbo_nxt[1] = ~turbo[1];
        end
        phase_nxt = tc_wrap ? ~phase : phase;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tcnt  <= '0;
            phase <= 1'b0;
            turbo <= 2'b00;
        end else begin
            tcnt  <= tc_wrap ? '0 : tcnt + 1'b1;
            phase <= phase_nxt;
            turbo <= turbo_nxt;
        end
    end
`else
    assign turbo_nxt = 2'b00;
    assign phase_nxt = 1'b0;
`endif

    // Cleaning runs on next-state buttons so joy_state lands one clock after the byte
    always_comb begin
        clean_nxt = btn_nxt;
        for (int p = 0; p < 2; p++) begin
            if (SOCD_NEUTRAL) begin
                if (clean_nxt[p*8+4] && clean_nxt[p*8+5]) begin
                    clean_nxt[p*8+4] = 1'b0;
                    clean_nxt[p*8+5] = 1'b0;
                end
                if (clean_nxt[p*8+6] && clean_nxt[p*8+7]) begin
                    clean_nxt[p*8+6] = 1'b0;
                    clean_nxt[p*8+7] = 1'b0;
                end
            end
            if (turbo_nxt[p]) begin
                clean_nxt[p*8 +: 2] = clean_nxt[p*8 +: 2] & {2{phase_nxt}};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            skip_cnt  <= 3'd0;
            btn       <= 16'h0000;
            joy_state <= '0;
        end else begin
            state     <= state_nxt;
            skip_cnt  <= skip_cnt_nxt;
            btn       <= btn_nxt;
            joy_state <= clean_nxt[8*PLAYERS-1:0];
        end
    end

    for (genvar g = 0; g < PLAYERS; g++) begin : g_pad
        logic [7:0] shreg;

        // Loads only while strobe is high, so key changes cannot disturb a read in progress
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                shreg <= 8'h00;
            end else if (strobe) begin
                shreg <= joy_state[g*8 +: 8];
            end else if (rd[g]) begin
                shreg <= {1'b1, shreg[7:1]};
            end
        end

        assign joy_bit[g] = strobe ? joy_state[g*8] : shreg[0];
    end

endmodule

// File: tb/tb_kbd_joypad.sv
// Bench for kbd_joypad: directed byte table, multi-cycle read/reset sequences, random traffic vs a held-key model.
module tb_kbd_joypad;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  ps2_data = 8'h00;
    logic        ps2_data_clk = 1'b0;
    logic        strobe = 1'b0;
    logic [1:0]  rd = 2'b00;
    logic [1:0]  joy_bit;
    logic [15:0] joy_state;

    int checks = 0;
    int errors = 0;

    kbd_joypad #(.PLAYERS(2), .SOCD_NEUTRAL(1'b1), .TURBO_DIV(833333)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ps2_data     (ps2_data),
        .ps2_data_clk (ps2_data_clk),
        .strobe       (strobe),
        .rd           (rd),
        .joy_bit      (joy_bit),
        .joy_state    (joy_state)
    );

    always #5 clock = ~clock;

    // Model: which scan codes are currently held, plus bytes of an unfinished sequence
    bit          held [256];
    logic [7:0]  pend [$];
    logic [7:0]  keymap [16] = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h75, 8'h72, 8'h6B, 8'h74,
                                 8'h42, 8'h4B, 8'h31, 8'h3A, 8'h1D, 8'h1B, 8'h1C, 8'h23};
    logic [7:0]  pool [24]   = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h75, 8'h72, 8'h6B, 8'h74,
                                 8'h42, 8'h4B, 8'h31, 8'h3A, 8'h1D, 8'h1B, 8'h1C, 8'h23,
                                 8'h05, 8'h06, 8'h12, 8'h59, 8'h14, 8'h77, 8'h0D, 8'h66};
    logic [7:0]  resp [4]    = '{8'hFA, 8'hAA, 8'hEE, 8'hFE};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void m_clear();
        for (int i = 0; i < 256; i++) held[i] = 1'b0;
        pend.delete();
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        bit ext, brk;
        pend.push_back(b);
        if (pend[0] == 8'hE1) begin
            if (pend.size() == 8) pend.delete();
            return;
        end
        if (b == 8'hE0 || b == 8'hF0) return;
        ext = 1'b0;
        brk = 1'b0;
        foreach (pend[i]) begin
            if (pend[i] == 8'hE0) ext = 1'b1;
            if (pend[i] == 8'hF0) brk = 1'b1;
        end
        pend.delete();
        if (ext && (b == 8'h12 || b == 8'h59)) return;
        held[b] = !brk;
    endfunction

    function automatic logic [15:0] m_state();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = held[keymap[i]];
        for (int p = 0; p < 2; p++) begin
            if (v[p*8+4] && v[p*8+5]) begin v[p*8+4] = 1'b0; v[p*8+5] = 1'b0; end
            if (v[p*8+6] && v[p*8+7]) begin v[p*8+6] = 1'b0; v[p*8+7] = 1'b0; end
        end
        return v;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        ps2_data     = b;
        ps2_data_clk = 1'b1;
        @(negedge clock);
        ps2_data_clk = 1'b0;
        m_byte(b);
    endtask

    task automatic pulse(input logic [1:0] m);
        @(negedge clock);
        rd = m;
        @(negedge clock);
        rd = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        m_clear();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic rand_seq();
        logic [7:0] c;
        int kind;
        c    = pool[$urandom_range(0, 23)];
        kind = $urandom_range(0, 7);
        case (kind)
            0, 1:    send(c);
            2, 5:    begin send(8'hF0); send(c); end
            3:       begin send(8'hE0); send(c); end
            4:       begin send(8'hE0); send(8'hF0); send(c); end
            6:       begin
                         send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
                         send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
                     end
            default: send(resp[$urandom_range(0, 3)]);
        endcase
        chk("rand_state", {16'h0, joy_state}, {16'h0, m_state()});
    endtask

    task automatic read_round();
        logic [15:0] e;
        logic [1:0]  m, want;
        int          idx0, idx1, n;
        e = m_state();
        @(negedge clock);
        strobe = 1'b1;
        @(negedge clock);
        chk("rand_strobe_bit", {30'h0, joy_bit}, {30'h0, e[8], e[0]});
        strobe = 1'b0;
        idx0 = 0;
        idx1 = 0;
        n = $urandom_range(1, 12);
        for (int j = 0; j < n; j++) begin
            want[0] = (idx0 < 8) ? e[idx0] : 1'b1;
            want[1] = (idx1 < 8) ? e[8 + idx1] : 1'b1;
            chk("rand_read_bit", {30'h0, joy_bit}, {30'h0, want});
            if ($urandom_range(0, 3) == 0) rand_seq();
            m = 2'($urandom_range(0, 3));
            pulse(m);
            if (m[0]) idx0++;
            if (m[1]) idx1++;
        end
    endtask

    typedef struct packed {
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [$];

    initial begin
        logic [9:0] seq4;

        tbl = '{
            '{8'h1A, 16'h0001}, '{8'hF0, 16'h0001}, '{8'h1A, 16'h0000},
            '{8'hE0, 16'h0000}, '{8'h75, 16'h0010}, '{8'hE0, 16'h0010}, '{8'h12, 16'h0010},
            '{8'hE0, 16'h0010}, '{8'hF0, 16'h0010}, '{8'h75, 16'h0000},
            '{8'h75, 16'h0010}, '{8'h72, 16'h0000}, '{8'hF0, 16'h0000}, '{8'h72, 16'h0010},
            '{8'hF0, 16'h0010}, '{8'h75, 16'h0000},
            '{8'hE1, 16'h0000}, '{8'h14, 16'h0000}, '{8'h77, 16'h0000}, '{8'hE1, 16'h0000},
            '{8'hF0, 16'h0000}, '{8'h14, 16'h0000}, '{8'hF0, 16'h0000}, '{8'h77, 16'h0000},
            '{8'h22, 16'h0002},
            '{8'h1D, 16'h1002}, '{8'h1B, 16'h0002}, '{8'h1C, 16'h4002}, '{8'h23, 16'h0002},
            '{8'hE0, 16'h0002}, '{8'h6B, 16'h0042}, '{8'hFA, 16'h0042}, '{8'h05, 16'h0042},
            '{8'hE0, 16'h0042}, '{8'hF0, 16'h0042}, '{8'h59, 16'h0042},
            '{8'hF0, 16'h0042}, '{8'h22, 16'h0040},
            '{8'hF0, 16'h0040}, '{8'h1D, 16'h2040}, '{8'hF0, 16'h2040}, '{8'h1B, 16'h0040},
            '{8'hF0, 16'h0040}, '{8'h1C, 16'h8040}, '{8'hF0, 16'h8040}, '{8'h23, 16'h0040},
            '{8'hE0, 16'h0040}, '{8'hF0, 16'h0040}, '{8'h6B, 16'h0000}
        };

        m_clear();
        repeat (3) @(negedge clock);
        chk("reset_state", {16'h0, joy_state}, 32'h0);
        chk("reset_bit", {30'h0, joy_bit}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset_state", {16'h0, joy_state}, 32'h0);

        foreach (tbl[i]) begin
            send(tbl[i].b);
            chk($sformatf("tbl[%0d]", i), {16'h0, joy_state}, {16'h0, tbl[i].exp});
        end

        // Serial read of Z + RT, with a key change mid-read
        send(8'h1A);
        send(8'h74);
        chk("rd_setup", {16'h0, joy_state}, 32'h0081);
        @(negedge clock);
        strobe = 1'b1;
        @(negedge clock);
        chk("strobe_bit", {30'h0, joy_bit}, 32'h1);
        pulse(2'b11);
        chk("rd_during_strobe", {30'h0, joy_bit}, 32'h1);
        strobe = 1'b0;
        seq4 = 10'b1110000001;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("serial[%0d]", k), {30'h0, joy_bit}, {30'h0, 1'b0, seq4[k]});
            if (k == 3) begin
                send(8'hF0);
                send(8'h1A);
                chk("midread_state", {16'h0, joy_state}, 32'h0080);
            end
            pulse(2'b01);
        end
        send(8'hF0);
        send(8'h74);

        // Reset during a pending prefix
        send(8'h1A);
        send(8'hE0);
        #2 reset_n = 1'b0;
        #1 chk("async_clear", {16'h0, joy_state}, 32'h0);
        m_clear();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        send(8'h75);
        chk("reset_e0_then_75", {16'h0, joy_state}, 32'h0010);
        send(8'hE0);
        send(8'hF0);
        #2 reset_n = 1'b0;
        m_clear();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        send(8'h72);
        chk("reset_e0f0_then_72", {16'h0, joy_state}, 32'h0020);

        do_reset();
        for (int it = 0; it < 250; it++) begin
            rand_seq();
            if ($urandom_range(0, 3) == 0) read_round();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
